led_data_formatter: RTL and testbench

Formats a 32-bit value from the CPU datapath into the 8-nibble word consumed by the eight-digit seven-segment display driver. It sits directly upstream of the display driver and drives that driver's 32-bit data input from a register that changes only on completed updates, so the display never shows partial results. Hex mode passes the value through. Decimal mode runs an iterative shift-add-3 (double-dabble) binary-to-BCD conversion and flags values that need more than 8 decimal digits.

---
 rtl/led_data_formatter_if.sv | 22 ++
 rtl/led_data_formatter.sv | 126 ++++++++++++
 tb/tb_led_data_formatter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/led_data_formatter_if.sv
// Write/result bus between the CPU-side writer and the display data formatter.
//   wr_en, wr_data, mode     : write request from the master
//   busy, done, disp_data, ovf : status and formatted result from the slave
interface led_data_formatter_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        mode;
    logic        busy;
    logic        done;
    logic [31:0] disp_data;
    logic        ovf;

    modport master (
        output wr_en, wr_data, mode,
        input  busy, done, disp_data, ovf
    );

    modport slave (
        input  wr_en, wr_data, mode,
        output busy, done, disp_data, ovf
    );
endinterface

// File: rtl/led_data_formatter.sv
// Formats a 32-bit value into the 8-nibble word for the seven-segment driver.
// Hex mode passes the value through; decimal mode runs a 32-step shift-add-3
// binary-to-BCD conversion and shows EEEEEEEE with ovf=1 above 99,999,999.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of led_data_formatter_if (write in, result out)
module led_data_formatter (
    input  logic                    clk,
    input  logic                    rst,
    led_data_formatter_if.slave     bus
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BCD_W   = 40;
    localparam int unsigned DIGITS  = BCD_W / 4;
    localparam int unsigned CNT_W   = 5;
    localparam logic [DATA_W-1:0] OVF_PATTERN = 32'hEEEE_EEEE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [DATA_W-1:0]  bin, bin_n;
    logic [BCD_W-1:0]   bcd, bcd_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               mode_q, mode_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic [DATA_W-1:0]  disp_q, disp_n;
    logic               ovf_q, ovf_n;
    logic [BCD_W-1:0]   bcd_adj;

    // Double-dabble correction: every digit >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = 4'(bcd[4*i +: 4] + 4'd3);
            end
        end
    end

    // State register and all datapath/output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            bin    <= '0;
            bcd    <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_n;
            bin    <= bin_n;
            bcd    <= bcd_n;
            cnt    <= cnt_n;
            mode_q <= mode_n;
            busy_q <= busy_n;
            done_q <= done_n;
            disp_q <= disp_n;
            ovf_q  <= ovf_n;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_n = state;
        bin_n   = bin;
        bcd_n   = bcd;
        cnt_n   = cnt;
        mode_n  = mode_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        disp_n  = disp_q;
        ovf_n   = ovf_q;

        unique case (state)
            IDLE: begin
                // busy is still high in the done cycle, so that cycle drops writes
                busy_n = 1'b0;
                if (bus.wr_en && !busy_q) begin
                    bin_n   = bus.wr_data;
                    mode_n  = bus.mode;
                    bcd_n   = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = bus.mode ? CONV : FINISH;
                end
            end
            CONV: begin
                {bcd_n, bin_n} = {bcd_adj[BCD_W-2:0], bin, 1'b0};
                cnt_n = CNT_W'(cnt + 1'b1);
                if (cnt == CNT_W'(31)) begin
                    state_n = FINISH;
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                state_n = IDLE;
                if (!mode_q) begin
                    disp_n = bin;
                    ovf_n  = 1'b0;
                end else if (bcd[BCD_W-1:DATA_W] != '0) begin
                    disp_n = OVF_PATTERN;
                    ovf_n  = 1'b1;
                end else begin
                    disp_n = bcd[DATA_W-1:0];
                    ovf_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.disp_data = disp_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_led_data_formatter.sv
// Self-checking bench for led_data_formatter: directed cases plus random
// values compared against a divide-by-ten decimal model.
module tb_led_data_formatter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    led_data_formatter_if bus ();

    led_data_formatter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by repeated division; >8 digits shows E's
    function automatic logic [31:0] ref_disp(input logic [31:0] v, input logic m);
        logic [31:0] r;
        longint unsigned x;
        if (!m) return v;
        x = longint'(v);
        if (x > 64'd99_999_999) return 32'hEEEE_EEEE;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] v, input logic m);
        return m && (v > 32'd99_999_999);
    endfunction

    // Issue one write from idle and check latency, result and overflow flag
    task automatic do_write(input string tag, input logic [31:0] v, input logic m);
        int k;
        bit seen;
        k = 0;
        while (bus.busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = v;
        bus.mode    = m;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
        seen = 1'b0;
        for (k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_latency"}, 32'(k), m ? 32'd33 : 32'd1);
            check({tag, "_data"}, bus.disp_data, ref_disp(v, m));
            check({tag, "_ovf"}, 32'(bus.ovf), 32'(ref_ovf(v, m)));
        end
        @(posedge clk);
        #1;
        check({tag, "_busy_clear"}, 32'(bus.busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int dones;
        int busy_bad;
        logic [31:0] v;
        logic m;

        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.mode    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_data", bus.disp_data, 32'd0);
        check("rst_ovf",  32'(bus.ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_write("dec_12345678", 32'd12_345_678, 1'b1);
        do_write("dec_zero",     32'd0,          1'b1);
        do_write("dec_max8",     32'd99_999_999, 1'b1);
        do_write("dec_1e8",      32'd100_000_000, 1'b1);
        do_write("dec_ffff",     32'hFFFF_FFFF,  1'b1);
        do_write("hex_deadbeef", 32'hDEAD_BEEF,  1'b0);

        // Decimal 5 with stray writes mid-conversion and during the done cycle
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'd5;
        bus.mode    = 1'b1;
        dones    = 0;
        busy_bad = 0;
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
            if (k >= 1 && bus.busy !== (k <= 33)) busy_bad++;
            @(negedge clk);
            bus.wr_en   = (k == 9 || k == 33);
            bus.wr_data = 32'd7;
            bus.mode    = 1'b0;
        end
        bus.wr_en = 1'b0;
        check("repulse_done_count", 32'(dones), 32'd1);
        check("repulse_busy_profile", 32'(busy_bad), 32'd0);
        check("repulse_data", bus.disp_data, 32'h0000_0005);
        check("repulse_ovf", 32'(bus.ovf), 32'd0);

        // Leave ovf set, then reset in the middle of a conversion
        do_write("pre_rst_ovf", 32'd123_456_789, 1'b1);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'hFFFF_FFFF;
        bus.mode    = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_ovf",  32'(bus.ovf), 32'd0);
        check("midrst_data", bus.disp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_write("hex_after_rst", 32'h0000_0042, 1'b0);

        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0: v = $urandom_range(99_999_999, 0);
                1: v = 32'd100_000_000 + 32'($urandom_range(32'hFFFF_FFFF - 32'd100_000_000, 0));
                default: v = $urandom;
            endcase
            m = (i % 4 != 3);
            do_write($sformatf("rand%0d", i), v, m);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
